// File: rtl/alarm_pkg.sv
// alarm_pkg: interval codes, timer state encoding and default clock rate shared by the alarm blocks.
package alarm_pkg;
    typedef enum logic [1:0] {ARM_DELAY, DRIVER_DELAY, PASSENGER_DELAY, ALARM_ON} interval_e;
    typedef enum logic [1:0] {IDLE, REQ, LOAD, COUNT} timer_state_e;
    localparam int DEFAULT_CLK_HZ = 27_000_000;
endpackage

// File: rtl/second_divider.sv
// second_divider: free-running 0..CLK_HZ-1 counter producing a one-cycle 1 Hz enable.
module second_divider
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic one_hz
);
    localparam int W = $clog2(CLK_HZ);
    localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);
    logic [W-1:0] count;
    always_ff @(posedge clk)
        if (reset || clear) count <= '0;
        else count <= one_hz ? '0 : count + 1'b1;
    assign one_hz = count == TERM;
endmodule

// File: rtl/alarm_timer.sv
// alarm_timer: requests an interval from the parameter store, loads it and counts it down in seconds.
module alarm_timer
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] interval_sel,
    output logic [1:0] interval,
    input  logic [3:0] value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz
);
    timer_state_e state, state_n;
    logic [1:0] interval_n;
    logic [3:0] remaining_n;
    logic busy_n, expired_n, clear;

    second_divider #(.CLK_HZ(CLK_HZ)) u_div (
        .clk(clk), .reset(reset), .clear(clear), .one_hz(one_hz)
    );

    always_ff @(posedge clk)
        if (reset) begin
            state     <= IDLE;
            interval  <= 2'b00;
            busy      <= 1'b0;
            expired   <= 1'b0;
            remaining <= 4'd0;
        end else begin
            state     <= state_n;
            interval  <= interval_n;
            busy      <= busy_n;
            expired   <= expired_n;
            remaining <= remaining_n;
        end

    // A start request overrides whatever the current state would do, including an expiry.
    always_comb begin
        state_n     = state;
        interval_n  = interval;
        busy_n      = busy;
        expired_n   = 1'b0;
        remaining_n = remaining;
        clear       = 1'b0;
        if (start) begin
            state_n    = REQ;
            interval_n = interval_sel;
            busy_n     = 1'b1;
        end else begin
            case (state)
                REQ: state_n = LOAD;
                LOAD: begin
                    remaining_n = value;
                    clear       = 1'b1;
                    expired_n   = value == 4'd0;
                    busy_n      = value != 4'd0;
                    state_n     = value == 4'd0 ? IDLE : COUNT;
                end
                COUNT:
                    if (one_hz) begin
                        remaining_n = remaining == 4'd0 ? 4'd0 : remaining - 4'd1;
                        expired_n   = remaining <= 4'd1;
                        busy_n      = remaining > 4'd1;
                        state_n     = remaining <= 4'd1 ? IDLE : COUNT;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_timer.sv
// tb_alarm_timer: randomized and directed stimulus checked every cycle against an edge-timestamp model.
module tb_alarm_timer;
    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] interval_sel = 2'b00;
    logic [1:0] interval;
    logic [3:0] value = 4'd0;
    logic       expired, busy, one_hz;
    logic [3:0] remaining;
    logic [3:0] tbl [4];

    int checks = 0;
    int errors = 0;

    alarm_timer #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .reset(reset), .start(start), .interval_sel(interval_sel),
        .interval(interval), .value(value), .expired(expired), .busy(busy),
        .remaining(remaining), .one_hz(one_hz)
    );

    always #5 clk = ~clk;

    // Parameter store stand-in: registered lookup of the requested interval.
    always @(posedge clk) value <= tbl[interval];

    // Model: everything expressed as edge timestamps.
    int  t = 0, load_edge = 0, exp_edge = 0, clr_edge = 0, m_n = 0, m_int = 0, m_hold = 0;
    bit  armed = 0, pending = 0, seg = 0, m_busy = 0, m_exp = 0;

    function automatic int rem_at(input int x);
        return x >= exp_edge ? 0 : m_n - (x - load_edge) / CLK_HZ;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, t, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        t++;
        m_exp = 0;
        if (reset) begin
            armed = 1; pending = 0; seg = 0; m_busy = 0; m_int = 0; m_hold = 0; clr_edge = t;
        end else if (start) begin
            if (seg) m_hold = rem_at(t - 1);
            seg = 0; pending = 1; load_edge = t + 2; m_int = interval_sel; m_busy = 1;
        end else if (pending && t == load_edge) begin
            pending = 0; seg = 1; clr_edge = t; m_n = tbl[m_int];
            exp_edge = t + m_n * CLK_HZ;
            if (m_n == 0) begin m_exp = 1; m_busy = 0; end
        end else if (seg && m_busy && t == exp_edge) begin
            m_exp = 1; m_busy = 0;
        end
        @(negedge clk);
        if (armed) begin
            chk("interval", int'(interval), m_int);
            chk("busy", int'(busy), int'(m_busy));
            chk("expired", int'(expired), int'(m_exp));
            chk("remaining", int'(remaining), seg ? rem_at(t) : m_hold);
            chk("one_hz", int'(one_hz), int'(((t - clr_edge) % CLK_HZ) == CLK_HZ - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input logic [1:0] sel);
        start = 1'b1;
        interval_sel = sel;
        @(negedge clk);
        start = 1'b0;
        interval_sel = 2'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = 4'd5;
        step(3);
        reset = 1'b0;
        step(20);
        chk("idle_interval", int'(interval), 0);
        chk("idle_remaining", int'(remaining), 0);

        tbl[1] = 4'd3;
        go(2'b01);
        chk("s1_interval", int'(interval), 1);
        step(2);  chk("s1_rem_e2", int'(remaining), 3);
        step(4);  chk("s1_rem_e6", int'(remaining), 2);
        step(4);  chk("s1_rem_e10", int'(remaining), 1);
        step(3);  chk("s1_noexp_e13", int'(expired), 0);
        step(1);  chk("s1_exp_e14", int'(expired), 1);
        chk("s1_busy_e14", int'(busy), 0);
        step(1);  chk("s1_exp_clear", int'(expired), 0);
        step(5);

        tbl[0] = 4'd0;
        go(2'b00);
        chk("s2_busy_e0", int'(busy), 1);
        step(2);  chk("s2_exp_e2", int'(expired), 1);
        chk("s2_busy_e2", int'(busy), 0);
        step(5);

        tbl[3] = 4'd10; tbl[2] = 4'd2;
        go(2'b11);
        step(7);
        start = 1'b1; interval_sel = 2'b10;
        step(1);
        start = 1'b0;
        chk("s3_interval", int'(interval), 2);
        chk("s3_rem_hold", int'(remaining), 9);
        step(9);  chk("s3_noexp_e17", int'(expired), 0);
        step(1);  chk("s3_exp_e18", int'(expired), 1);
        step(5);

        tbl[1] = 4'd7;
        go(2'b01);
        step(10); chk("s4_rem_e10", int'(remaining), 5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("s4_busy", int'(busy), 0);
        chk("s4_rem", int'(remaining), 0);
        step(40);

        tbl[0] = 4'd15;
        go(2'b00);
        step(2);  chk("s5_rem_e2", int'(remaining), 15);
        step(59); chk("s5_rem_e61", int'(remaining), 1);
        step(1);  chk("s5_exp_e62", int'(expired), 1);
        chk("s5_rem_e62", int'(remaining), 0);
        step(5);

        for (int blk = 0; blk < 8; blk++) begin
            int p = 4 + blk * 10;
            for (int c = 0; c < 500; c++) begin
                if (!pending && $urandom_range(0, 19) == 0) tbl[$urandom_range(0, 3)] = 4'($urandom);
                reset = $urandom_range(0, 299) == 0;
                start = $urandom_range(0, p - 1) == 0;
                interval_sel = 2'($urandom);
                step(1);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        step(80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
